// File: rtl/fetch_prefetch_unit.sv
// Instruction prefetcher. It issues sequential icache reads, tracks in-flight
// reads and buffers returned words with their PCs in a small queue for decode.
// A redirect flushes the queue and discards any responses still in flight.
module fetch_prefetch_unit #(
    parameter int unsigned       ADDR_W    = 32,
    parameter int unsigned       DATA_W    = 32,
    parameter int unsigned       DEPTH     = 8,
    parameter int unsigned       MAX_OUTST = 4,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [ADDR_W-1:0] PC_INC    = ADDR_W'(4)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              jtag_reset_flag_i,
    input  logic              jump_flag_i,
    input  logic [ADDR_W-1:0] jump_addr_i,
    input  logic              hold_i,
    output logic              inst_valid_o,
    output logic [ADDR_W-1:0] inst_addr_o,
    output logic [DATA_W-1:0] inst_o,
    output logic [ADDR_W-1:0] o_p_addr,
    output logic              o_p_read,
    input  logic [DATA_W-1:0] i_p_readdata,
    input  logic              i_p_readdata_valid,
    input  logic              i_p_waitrequest
);

    localparam int unsigned QAW = $clog2(DEPTH);
    localparam int unsigned QCW = $clog2(DEPTH + 1);
    localparam int unsigned OCW = $clog2(MAX_OUTST + 1);
    localparam int unsigned RAW = (MAX_OUTST > 1) ? $clog2(MAX_OUTST) : 1;

    // Architectural state
    logic [ADDR_W-1:0] fetch_pc;
    logic              stale;
    logic [OCW-1:0]    outstanding;
    logic [OCW-1:0]    drop_cnt;

    // PCs of accepted reads, in order, waiting for their data
    logic [ADDR_W-1:0] rp_mem [MAX_OUTST];
    logic [RAW-1:0]    rp_rd;
    logic [RAW-1:0]    rp_wr;

    // Instruction queue; the head entry is mirrored into the inst_* registers
    logic [DATA_W-1:0] q_data [DEPTH];
    logic [ADDR_W-1:0] q_pc   [DEPTH];
    logic [QAW-1:0]    q_rd;
    logic [QAW-1:0]    q_wr;
    logic [QCW-1:0]    q_count;

    // Per-cycle events
    logic              accept;
    logic              redirect;
    logic              drop_resp;
    logic              push;
    logic              pop;
    logic [ADDR_W-1:0] target;
    logic [ADDR_W-1:0] resp_pc;

    // Next-state values
    logic [OCW-1:0]    out_n;
    logic [OCW-1:0]    drop_n;
    logic [QCW-1:0]    q_count_n;
    logic [QCW-1:0]    q_left;
    logic [QAW-1:0]    q_rd_n;
    logic [QAW-1:0]    q_wr_n;
    logic [RAW-1:0]    rp_rd_n;
    logic [RAW-1:0]    rp_wr_n;
    logic [ADDR_W-1:0] fetch_pc_n;
    logic              stale_n;
    logic              read_n;
    logic [ADDR_W-1:0] addr_n;
    logic              valid_n;
    logic [ADDR_W-1:0] head_pc_n;
    logic [DATA_W-1:0] head_data_n;

    // Wrapping increment for the response-PC FIFO, which need not be a power of 2
    function automatic logic [RAW-1:0] rp_inc(input logic [RAW-1:0] p);
        return (32'(p) == MAX_OUTST - 1) ? '0 : p + RAW'(1);
    endfunction

    assign accept    = o_p_read & ~i_p_waitrequest;
    assign redirect  = jump_flag_i | jtag_reset_flag_i;
    assign drop_resp = i_p_readdata_valid & (drop_cnt != '0);
    assign push      = i_p_readdata_valid & (drop_cnt == '0) & ~redirect;
    assign pop       = inst_valid_o & ~hold_i & ~redirect;
    assign target    = jtag_reset_flag_i ? RESET_PC : {jump_addr_i[ADDR_W-1:2], 2'b00};
    assign resp_pc   = rp_mem[rp_rd];

    // Next-state computation for counters, fetch PC, request and queue head
    always_comb begin
        // NOTE: every signal gets a default at the top so no path leaves it
        // unassigned; a missing default here would infer a latch.
        out_n       = outstanding + OCW'(accept) - OCW'(i_p_readdata_valid);
        drop_n      = drop_cnt - OCW'(drop_resp) + OCW'(accept & stale);
        q_count_n   = q_count + QCW'(push) - QCW'(pop);
        q_left      = q_count - QCW'(pop);
        q_rd_n      = q_rd + QAW'(pop);
        q_wr_n      = q_wr + QAW'(push);
        rp_rd_n     = i_p_readdata_valid ? rp_inc(rp_rd) : rp_rd;
        rp_wr_n     = accept ? rp_inc(rp_wr) : rp_wr;
        fetch_pc_n  = (accept & ~stale) ? fetch_pc + PC_INC : fetch_pc;
        stale_n     = accept ? 1'b0 : stale;
        read_n      = o_p_read;
        addr_n      = o_p_addr;
        valid_n     = 1'b0;
        head_pc_n   = inst_addr_o;
        head_data_n = inst_o;

        // Everything in flight after this cycle's accept/return becomes stale
        if (redirect) begin
            drop_n     = out_n;
            q_count_n  = '0;
            q_rd_n     = '0;
            q_wr_n     = '0;
            fetch_pc_n = target;
            if (o_p_read & i_p_waitrequest) begin
                stale_n = 1'b1;
            end
        end

        // A stalled request is frozen; otherwise re-evaluate the issue rule,
        // reserving a queue slot for every read in flight
        if (!(o_p_read & i_p_waitrequest)) begin
            read_n = (32'(out_n) < MAX_OUTST) &&
                     ((32'(q_count_n) + 32'(out_n)) < DEPTH);
            addr_n = fetch_pc_n;
        end

        // Queue head: bypass a push into an otherwise empty queue
        if (q_count_n != '0) begin
            valid_n = 1'b1;
            if (q_left == '0) begin
                head_pc_n   = resp_pc;
                head_data_n = i_p_readdata;
            end else begin
                head_pc_n   = q_pc[q_rd_n];
                head_data_n = q_data[q_rd_n];
            end
        end
    end

    // Control state and registered outputs, synchronous active-low reset
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values, independent of statement order.
        if (!rst_n) begin
            fetch_pc     <= RESET_PC;
            stale        <= 1'b0;
            outstanding  <= '0;
            drop_cnt     <= '0;
            rp_rd        <= '0;
            rp_wr        <= '0;
            q_rd         <= '0;
            q_wr         <= '0;
            q_count      <= '0;
            o_p_read     <= 1'b0;
            o_p_addr     <= RESET_PC;
            inst_valid_o <= 1'b0;
            inst_addr_o  <= '0;
            inst_o       <= '0;
        end else begin
            fetch_pc     <= fetch_pc_n;
            stale        <= stale_n;
            outstanding  <= out_n;
            drop_cnt     <= drop_n;
            rp_rd        <= rp_rd_n;
            rp_wr        <= rp_wr_n;
            q_rd         <= q_rd_n;
            q_wr         <= q_wr_n;
            q_count      <= q_count_n;
            o_p_read     <= read_n;
            o_p_addr     <= addr_n;
            inst_valid_o <= valid_n;
            inst_addr_o  <= head_pc_n;
            inst_o       <= head_data_n;
        end
    end

    // Storage arrays: written on push/accept only
    always_ff @(posedge clk) begin
        // NOTE: the arrays are not reset; pointers and counts are, and no entry
        // is read before it has been written, so clearing them buys nothing.
        if (push) begin
            q_data[q_wr] <= i_p_readdata;
            q_pc[q_wr]   <= resp_pc;
        end
        if (accept) begin
            rp_mem[rp_wr] <= o_p_addr;
        end
    end

endmodule

// File: doc/fetch_prefetch_unit.md
Name: fetch_prefetch_unit

Overview:
Parametrised instruction prefetcher for the core front end. It replaces the separate PC / address-FIFO / inst-FIFO / fetch arrangement with one block.
- Issues sequential fetch reads to the icache port.
- Keeps up to MAX_OUTST reads in flight.
- Buffers returned words with their PCs in a DEPTH-entry queue and presents them to decode.
- On a jump or JTAG reset it flushes the queue, discards responses already in flight and restarts at the new PC.

Parameters:
ADDR_W, 32, instruction address width
DATA_W, 32, instruction word width
DEPTH, 8, instruction queue entries (power of 2, >=2)
MAX_OUTST, 4, max accepted-but-unreturned reads (1..DEPTH)
RESET_PC, 0, fetch start address after reset or jtag reset
PC_INC, 4, sequential address increment

Ports:
clk  in  1  clock
rst_n  in  1  reset, synchronous, active-low
jtag_reset_flag_i  in  1  redirect to RESET_PC (same handling as jump)
jump_flag_i  in  1  redirect request
jump_addr_i  in  ADDR_W  redirect target; bits [1:0] forced to 0
hold_i  in  1  decode stall; high = do not consume
inst_valid_o  out  1  inst_o/inst_addr_o valid
inst_addr_o  out  ADDR_W  PC of presented instruction
inst_o  out  DATA_W  presented instruction
o_p_addr  out  ADDR_W  icache read address
o_p_read  out  1  icache read request
i_p_readdata  in  DATA_W  icache read data
i_p_readdata_valid  in  1  read data valid, one pulse per accepted read, in order
i_p_waitrequest  in  1  icache not accepting the request this cycle

Behaviour:
- Single clock domain. rst_n is sampled at posedge clk only.
- Reset state:
  - inst_valid_o=0, inst_addr_o=0, inst_o=0, o_p_read=0, o_p_addr=RESET_PC.
  - Queue empty, outstanding=0, drop_cnt=0, fetch_pc=RESET_PC.
- Request acceptance and stalling:
  - A request is accepted in a cycle where o_p_read & ~i_p_waitrequest.
  - While o_p_read=1 and i_p_waitrequest=1, o_p_addr and o_p_read hold unchanged. This applies even across a redirect.
- Issue rule:
  - o_p_read is asserted for fetch_pc when outstanding < MAX_OUTST and q_count + outstanding < DEPTH.
  - This reserves a queue slot for every in-flight read, so a response never meets a full queue.
  - On acceptance: fetch_pc += PC_INC and outstanding += 1.
  - Back-to-back issue is allowed, one acceptance per cycle max.
- Response handling:
  - Each i_p_readdata_valid decrements outstanding.
  - If drop_cnt>0, the response is discarded and drop_cnt decrements.
  - Otherwise {resp_pc, data} is pushed, where resp_pc is a FIFO of accepted addresses (depth MAX_OUTST).
- Output:
  - Head of queue drives inst_*_o, registered.
  - Push into an empty queue at cycle M gives inst_valid_o=1 at M+1.
  - Entry is consumed in a cycle with inst_valid_o & ~hold_i. The next entry, if any, appears the following cycle with no bubble.
  - While hold_i=1, outputs are stable.
- Redirect (jump_flag_i | jtag_reset_flag_i), effective at the clock edge:
  - Queue cleared; inst_valid_o=0 next cycle.
  - fetch_pc = target: RESET_PC if jtag_reset_flag_i, else jump_addr_i. jtag has priority if both are asserted.
  - drop_cnt = outstanding after this cycle's accept/return. So a response in the same cycle as the redirect is discarded, and a read accepted in the same cycle is counted for dropping.
  - If a request is stalled (o_p_read=1, waitrequest=1), it is flagged stale. On its later acceptance drop_cnt increments, fetch_pc does not advance, and the next issue uses the new target.
  - With no stalled request, the first read of the target is issued at redirect cycle+1.
  - Redirect overrides hold_i.
- Boundary cases:
  - Repeated redirects accumulate correctly: drop_cnt never underflows and equals the count of stale in-flight reads.
  - fetch_pc wraps modulo 2^ADDR_W.
  - q_count == DEPTH with hold_i=1: no issue.
  - rst_n low mid-transaction returns to the reset state; responses arriving afterwards are the system's responsibility, since the cache resets with the same reset.

Test Plan:
- Reset, icache zero-wait with 1-cycle read latency, hold_i=0 -> reads at 0x0,0x4,0x8… on consecutive cycles; inst_valid_o first high 2 cycles after the first acceptance; inst_addr_o increments by 4 each cycle.
- hold_i=1 for 20 cycles with DEPTH=8, MAX_OUTST=4 -> exactly 8 reads accepted; o_p_read then 0; inst_o stable; releasing hold drains 8 entries on consecutive cycles with no loss.
- 3 reads in flight, jump to 0x100 -> the 3 old responses are discarded; next inst_valid_o shows inst_addr_o=0x100, then 0x104.
- Jump while o_p_read stalled on waitrequest at 0x20 -> 0x20 is held until accepted, its data is dropped, and the next request is 0x200 (the jump target).
- Jump in the same cycle as i_p_readdata_valid and acceptance -> both the returning response and the newly accepted read are dropped; drop_cnt returns to 0.
- jtag_reset_flag_i and jump_flag_i together -> fetch restarts at RESET_PC; rst_n low for 1 cycle mid-burst -> all outputs return to their reset values the next cycle.
